// File: rtl/dmem_pkg.sv
// Shared encodings, FSM state type and request legality check for the data memory.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // A request is bad when its size is reserved or its address is not
    // naturally aligned to the access size.
    function automatic logic is_bad_request(input logic [1:0] size, input logic [1:0] byte_off);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = byte_off[0];
            SZ_WORD: bad = (byte_off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between the MEM stage (master) and the data memory (slave).
//
// Handshake: a request transfers on a rising edge where req_valid and req_ready
// are both high; the request fields are only looked at on that edge. The
// response is a single-cycle rsp_valid pulse, and rdata/err are meaningful only
// while rsp_valid is high. There is no response back-pressure.
interface dmem_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic                     req_valid;
    logic                     req_write;
    logic [1:0]               req_size;
    logic                     req_unsigned;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    wdata;
    logic                     req_ready;
    logic                     rsp_valid;
    logic [DATA_WIDTH-1:0]    rdata;
    logic                     err;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, addr, wdata,
        input  req_ready, rsp_valid, rdata, err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, addr, wdata,
        output req_ready, rsp_valid, rdata, err
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering: store byte enables and data replication, and
// load lane selection with sign or zero extension.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  byte_off,
    input  logic        is_unsigned,
    input  logic [31:0] store_data,
    input  logic [31:0] mem_word,
    output logic [3:0]  byte_en,
    output logic [31:0] store_word,
    output logic [31:0] load_data
);
    logic [31:0] shifted;
    logic [7:0]  load_byte;
    logic [15:0] load_half;

    // Replicate store data across lanes so the byte enables alone pick the target lanes.
    always_comb begin
        byte_en    = 4'b0000;
        store_word = 32'd0;
        load_data  = 32'd0;
        shifted    = mem_word >> {byte_off, 3'b000};
        load_byte  = shifted[7:0];
        load_half  = byte_off[1] ? mem_word[31:16] : mem_word[15:0];
        case (size)
            SZ_BYTE: begin
                byte_en    = 4'b0001 << byte_off;
                store_word = {4{store_data[7:0]}};
                load_data  = is_unsigned ? {24'd0, load_byte} : {{24{load_byte[7]}}, load_byte};
            end
            SZ_HALF: begin
                byte_en    = byte_off[1] ? 4'b1100 : 4'b0011;
                store_word = {2{store_data[15:0]}};
                load_data  = is_unsigned ? {16'd0, load_half} : {{16{load_half[15]}}, load_half};
            end
            SZ_WORD: begin
                byte_en    = 4'b1111;
                store_word = store_data;
                load_data  = mem_word;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/dmem_ctrl.sv
// Multi-cycle word-organised data memory with sub-word access, misalignment
// detection and a fixed number of wait states per good access.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 256,
    parameter int WAIT_STATES   = 1
) (
    input  logic   clk,
    input  logic   rst,
    dmem_if.slave  bus,
    output state_t dbg_state
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int LOW_W = IDX_W + 2;
    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  commit;
    logic                  wr_q, uns_q;
    logic [1:0]            size_q;
    logic [LOW_W-1:0]      addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  in_idle, accept;
    logic                  cur_write, cur_uns, cur_bad;
    logic [1:0]            cur_size;
    logic [LOW_W-1:0]      cur_addr;
    logic [DATA_WIDTH-1:0] cur_wdata;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] rword, store_word, load_data;
    logic [3:0]            byte_en;
    logic                  unused_addr_bits;

    assign in_idle       = (state_q == ST_IDLE);
    assign bus.req_ready = in_idle && !rst;
    assign accept        = bus.req_valid && bus.req_ready;
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rdata     = rdata_q;
    assign bus.err       = err_q;
    assign dbg_state     = state_q;

    // With zero wait states the commit happens on the accept edge, so the
    // live bus fields are used in IDLE and the latched copy everywhere else.
    assign cur_write = in_idle ? bus.req_write              : wr_q;
    assign cur_uns   = in_idle ? bus.req_unsigned           : uns_q;
    assign cur_size  = in_idle ? bus.req_size               : size_q;
    assign cur_addr  = in_idle ? bus.addr[LOW_W-1:0]        : addr_q;
    assign cur_wdata = in_idle ? bus.wdata                  : wdata_q;
    assign cur_bad   = is_bad_request(cur_size, cur_addr[1:0]);
    assign idx       = cur_addr[LOW_W-1:2];
    assign rword     = mem[idx];

    // Upper address bits are deliberately ignored so addresses wrap.
    assign unused_addr_bits = ^bus.addr[ADDRESS_WIDTH-1:LOW_W];

    dmem_lane_align u_align (
        .size        (cur_size),
        .byte_off    (cur_addr[1:0]),
        .is_unsigned (cur_uns),
        .store_data  (cur_wdata),
        .mem_word    (rword),
        .byte_en     (byte_en),
        .store_word  (store_word),
        .load_data   (load_data)
    );

    // Next-state, wait counter and commit strobe.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (cur_bad) begin
                        state_d = ST_RESP;
                    end else if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WS_LOAD;
                    end else begin
                        state_d = ST_RESP;
                        commit  = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counter, latched request and registered response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= SZ_BYTE;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                wr_q    <= bus.req_write;
                uns_q   <= bus.req_unsigned;
                size_q  <= bus.req_size;
                addr_q  <= bus.addr[LOW_W-1:0];
                wdata_q <= bus.wdata;
            end
            if (state_d == ST_RESP) begin
                err_q   <= cur_bad;
                rdata_q <= (commit && !cur_write) ? load_data : '0;
            end
        end
    end

    // Store commit; reset on the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && commit && cur_write) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[idx][i*8 +: 8] <= store_word[i*8 +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: two instances (2 wait states / 256 words and
// 0 wait states / 4 words) checked against a byte-addressed reference model.
module tb_dmem_ctrl;
    import dmem_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) if0 ();
    dmem_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) if1 ();
    state_t st0, st1;

    dmem_ctrl #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(2)) dut0 (
        .clk(clk), .rst(rst), .bus(if0), .dbg_state(st0));
    dmem_ctrl #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4), .WAIT_STATES(0)) dut1 (
        .clk(clk), .rst(rst), .bus(if1), .dbg_state(st1));

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  m0 [int];
    logic [7:0]  m1 [int];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int wait_states(input int sel);
        return (sel == 0) ? 2 : 0;
    endfunction

    function automatic logic [31:0] span_mask(input int sel);
        return (sel == 0) ? 32'd1023 : 32'd15;
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic model_bad(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    endfunction

    function automatic logic [31:0] model_load(input int sel, input logic [1:0] sz,
                                               input logic u, input logic [31:0] a);
        logic [31:0] v;
        logic [7:0]  bt;
        int base;
        v = 32'd0;
        base = int'(a & span_mask(sel));
        for (int k = 0; k < nbytes(sz); k++) begin
            bt = (sel == 0) ? m0[base + k] : m1[base + k];
            v = v | ({24'd0, bt} << (8 * k));
        end
        if (sz == 2'd0 && !u) v = {{24{v[7]}}, v[7:0]};
        if (sz == 2'd1 && !u) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    task automatic model_store(input int sel, input logic [1:0] sz, input logic [31:0] a,
                               input logic [31:0] d);
        int base;
        base = int'(a & span_mask(sel));
        for (int k = 0; k < nbytes(sz); k++) begin
            if (sel == 0) m0[base + k] = d[8*k +: 8];
            else          m1[base + k] = d[8*k +: 8];
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input int sel, input logic v, input logic w, input logic [1:0] sz,
                         input logic u, input logic [31:0] a, input logic [31:0] d);
        if (sel == 0) begin
            if0.req_valid = v; if0.req_write = w; if0.req_size = sz;
            if0.req_unsigned = u; if0.addr = a; if0.wdata = d;
        end else begin
            if1.req_valid = v; if1.req_write = w; if1.req_size = sz;
            if1.req_unsigned = u; if1.addr = a; if1.wdata = d;
        end
    endtask

    function automatic logic get_ready(input int sel);
        return (sel == 0) ? if0.req_ready : if1.req_ready;
    endfunction
    function automatic logic get_rsp(input int sel);
        return (sel == 0) ? if0.rsp_valid : if1.rsp_valid;
    endfunction
    function automatic logic [31:0] get_rdata(input int sel);
        return (sel == 0) ? if0.rdata : if1.rdata;
    endfunction
    function automatic logic get_err(input int sel);
        return (sel == 0) ? if0.err : if1.err;
    endfunction

    // Issue one request, wait for acceptance and the response pulse; lat is
    // the number of cycles after the accept edge until rsp_valid is seen.
    task automatic do_req(input int sel, input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic e, output int lat);
        int n;
        n = 0;
        drive(sel, 1'b1, w, sz, u, a, d);
        @(negedge clk);
        while (get_ready(sel) !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("accept_in_time", 32'(n < 40), 32'd1);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (get_rsp(sel) === 1'b1) break;
            check("ready_low_busy", 32'(get_ready(sel)), 32'd0);
        end
        check("ready_low_resp", 32'(get_ready(sel)), 32'd0);
        rd = get_rdata(sel);
        e  = get_err(sel);
    endtask

    task automatic run_op(input int sel, input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] d, input string tag,
                          output logic [31:0] rd);
        logic exp_err, e;
        int   exp_lat, lat;
        exp_err = model_bad(sz, a);
        exp_q.push_back((w || exp_err) ? 32'd0 : model_load(sel, sz, u, a));
        exp_lat = exp_err ? 1 : wait_states(sel) + 1;
        do_req(sel, w, sz, u, a, d, rd, e, lat);
        check({tag, "_rdata"}, rd, exp_q.pop_front());
        check({tag, "_err"}, 32'(e), 32'(exp_err));
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        if (w && !exp_err) model_store(sel, sz, a, d);
    endtask

    // Store to addr on dut0, then assert reset delay cycles after acceptance.
    task automatic reset_during_store(input int delay, input logic [31:0] a);
        int n;
        n = 0;
        drive(0, 1'b1, 1'b1, SZ_WORD, 1'b0, a, 32'hFFFF_FFFF);
        @(negedge clk);
        while (if0.req_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("rst_accept_in_time", 32'(n < 40), 32'd1);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            check("no_rsp_before_rst", 32'(if0.rsp_valid), 32'd0);
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("ready_low_in_rst", 32'(if0.req_ready), 32'd0);
            check("no_rsp_in_rst", 32'(if0.rsp_valid), 32'd0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("no_rsp_after_rst", 32'(if0.rsp_valid), 32'd0);
        end
        check("ready_after_rst", 32'(if0.req_ready), 32'd1);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        logic [1:0]  sz;

        drive(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready0", 32'(if0.req_ready), 32'd0);
        check("rst_rsp0", 32'(if0.rsp_valid), 32'd0);
        check("rst_rdata0", if0.rdata, 32'd0);
        check("rst_err0", 32'(if0.err), 32'd0);
        check("rst_state0", 32'(st0), 32'(ST_IDLE));
        check("rst_rsp1", 32'(if1.rsp_valid), 32'd0);
        check("rst_rdata1", if1.rdata, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready0_after_rst", 32'(if0.req_ready), 32'd1);
        check("ready1_after_rst", 32'(if1.req_ready), 32'd1);

        // Fill the working region of dut0 with known words.
        for (int i = 0; i < 16; i++)
            run_op(0, 1'b1, SZ_WORD, 1'b0, 32'(i * 4), $urandom, "init0", rd);

        run_op(0, 1'b1, SZ_WORD, 1'b0, 32'h8, 32'hDEAD_BEEF, "sw_8", rd);
        run_op(0, 1'b0, SZ_BYTE, 1'b0, 32'h9, 32'd0, "lb_9", rd);
        check("lb_9_const", rd, 32'hFFFF_FFBE);
        run_op(0, 1'b0, SZ_BYTE, 1'b1, 32'h9, 32'd0, "lbu_9", rd);
        check("lbu_9_const", rd, 32'h0000_00BE);
        run_op(0, 1'b0, SZ_HALF, 1'b0, 32'hA, 32'd0, "lh_a", rd);
        check("lh_a_const", rd, 32'hFFFF_DEAD);
        run_op(0, 1'b1, SZ_HALF, 1'b0, 32'hA, 32'h0000_1234, "sh_a", rd);
        run_op(0, 1'b0, SZ_WORD, 1'b0, 32'h8, 32'd0, "lw_8a", rd);
        check("lw_8a_const", rd, 32'h1234_BEEF);
        run_op(0, 1'b1, SZ_BYTE, 1'b0, 32'hB, 32'h0000_0077, "sb_b", rd);
        run_op(0, 1'b0, SZ_WORD, 1'b0, 32'h8, 32'd0, "lw_8b", rd);
        check("lw_8b_const", rd, 32'h7734_BEEF);

        run_op(0, 1'b0, SZ_WORD, 1'b0, 32'h6, 32'd0, "lw_6_bad", rd);
        run_op(0, 1'b0, SZ_HALF, 1'b0, 32'h3, 32'd0, "lh_3_bad", rd);
        run_op(0, 1'b1, 2'b11, 1'b0, 32'h4, 32'hFFFF_FFFF, "sz11_bad", rd);
        run_op(0, 1'b0, SZ_WORD, 1'b0, 32'h4, 32'd0, "lw_4", rd);

        run_op(0, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'h1357_9BDF, "sw_10", rd);
        reset_during_store(0, 32'h10);
        run_op(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'd0, "lw_10_wait_rst", rd);
        check("lw_10_wait_rst_const", rd, 32'h1357_9BDF);
        reset_during_store(1, 32'h10);
        run_op(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'd0, "lw_10_edge_rst", rd);
        check("lw_10_edge_rst_const", rd, 32'h1357_9BDF);

        for (int i = 0; i < 40; i++) begin
            a  = ($urandom_range(0, 3) << 10) | $urandom_range(0, 63);
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0 && sz != 2'b11)
                a = a & ~32'(nbytes(sz) - 1);
            run_op(0, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
                   "rnd0", rd);
        end

        // Zero wait states, 4-word memory: wrap-around and T+1 responses.
        run_op(1, 1'b1, SZ_WORD, 1'b0, 32'h0, 32'h0000_00A5, "sw1_0", rd);
        run_op(1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'd0, "lw1_10", rd);
        check("lw1_10_const", rd, 32'h0000_00A5);
        for (int i = 1; i < 4; i++)
            run_op(1, 1'b1, SZ_WORD, 1'b0, 32'(i * 4), $urandom, "init1", rd);
        for (int i = 0; i < 25; i++) begin
            a  = $urandom_range(0, 63);
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0 && sz != 2'b11)
                a = a & ~32'(nbytes(sz) - 1);
            run_op(1, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
                   "rnd1", rd);
        end

        // ---------------- final report ----------------
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
